// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared screen geometry, coordinate widths and FSM state type
//               for the game-object motion logic.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int STEP_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/axis_bounce.sv
`default_nettype none
// ============================================================================
// Module      : axis_bounce
// Description : Combinational one-axis position/direction update with wall
//               clamping and bounce detection.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_bounce #(
    parameter int W     = 10,
    parameter int LIMIT = 632,
    parameter int SW    = 4
) (
    input  logic [W-1:0]  pos_i,
    input  logic          dir_i,
    input  logic [SW-1:0] step_i,
    input  logic          tick_i,
    output logic [W-1:0]  pos_o,
    output logic          dir_o,
    output logic          bounce_o
);

    localparam logic [W:0]   c_LIMIT = (W+1)'(LIMIT);
    localparam logic [W-1:0] c_MAX   = W'(LIMIT);

    logic [W:0]   w_sum;
    logic [W-1:0] w_step;

    // One extra bit on the sum so the far-wall comparison never sees a wrap.
    assign w_step = W'(step_i);
    assign w_sum  = {1'b0, pos_i} + {1'b0, w_step};

    always_comb begin
        pos_o    = pos_i;
        dir_o    = dir_i;
        bounce_o = 1'b0;
        if (tick_i) begin
            if (dir_i) begin
                if (w_sum >= c_LIMIT) begin
                    pos_o    = c_MAX;
                    dir_o    = 1'b0;
                    bounce_o = 1'b1;
                end else begin
                    pos_o = w_sum[W-1:0];
                end
            end else begin
                if (pos_i <= w_step) begin
                    pos_o    = '0;
                    dir_o    = 1'b1;
                    bounce_o = 1'b1;
                end else begin
                    pos_o = pos_i - w_step;
                end
            end
        end
    end

endmodule : axis_bounce
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion
// Description : Per-frame ball motion with edge bounces and serve/pause FSM.
//               Optional macro BALL_SPEEDUP_EN: step grows by one per bounce.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_motion
    import game_pkg::*;
#(
    parameter int BALL_SIZE = 8,
    parameter int STEP      = 2,
    parameter int STEP_MAX  = 6,
    parameter int X_INIT    = 316,
    parameter int Y_INIT    = 236
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           serve,
    input  logic           enable,
    output logic [X_W-1:0] x0,
    output logic [X_W-1:0] x1,
    output logic [Y_W-1:0] y0,
    output logic [Y_W-1:0] y1,
    output logic           dir_x,
    output logic           dir_y,
    output logic           bounce_x,
    output logic           bounce_y,
    output logic           running
);

    localparam int c_STEP0 = (STEP > STEP_MAX) ? STEP_MAX : STEP;

    state_t           state_q, state_d;
    logic [X_W-1:0]   x0_q, x0_d;
    logic [Y_W-1:0]   y0_q, y0_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic             bounce_x_q, bounce_x_d;
    logic             bounce_y_q, bounce_y_d;
    logic [STEP_W-1:0] step_w;
    logic             move_w;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && serve) state_d = RUN;
    end

    always_comb begin
        running = (state_q == RUN);
    end

    // The serve cycle is still IDLE, so a coincident tick never moves the ball.
    assign move_w = (state_q == RUN) && frame_tick && enable;

    axis_bounce #(.W(X_W), .LIMIT(SCREEN_W - BALL_SIZE), .SW(STEP_W)) u_axis_x (
        .pos_i    (x0_q),
        .dir_i    (dir_x_q),
        .step_i   (step_w),
        .tick_i   (move_w),
        .pos_o    (x0_d),
        .dir_o    (dir_x_d),
        .bounce_o (bounce_x_d)
    );

    axis_bounce #(.W(Y_W), .LIMIT(SCREEN_H - BALL_SIZE), .SW(STEP_W)) u_axis_y (
        .pos_i    (y0_q),
        .dir_i    (dir_y_q),
        .step_i   (step_w),
        .tick_i   (move_w),
        .pos_o    (y0_d),
        .dir_o    (dir_y_d),
        .bounce_o (bounce_y_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x0_q       <= X_W'(X_INIT);
            y0_q       <= Y_W'(Y_INIT);
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b1;
            bounce_x_q <= 1'b0;
            bounce_y_q <= 1'b0;
        end else begin
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            bounce_x_q <= bounce_x_d;
            bounce_y_q <= bounce_y_d;
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [STEP_W-1:0] step_q, step_d;

    // A corner hit raises both bounce flags but counts as one event.
    always_comb begin
        step_d = step_q;
        if ((bounce_x_d || bounce_y_d) && (step_q < STEP_W'(STEP_MAX)))
            step_d = step_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) step_q <= STEP_W'(c_STEP0);
        else       step_q <= step_d;
    end

    assign step_w = step_q;
`else
    assign step_w = STEP_W'(c_STEP0);
`endif

    assign x0       = x0_q;
    assign y0       = y0_q;
    assign x1       = x0_q + X_W'(BALL_SIZE - 1);
    assign y1       = y0_q + Y_W'(BALL_SIZE - 1);
    assign dir_x    = dir_x_q;
    assign dir_y    = dir_y_q;
    assign bounce_x = bounce_x_q;
    assign bounce_y = bounce_y_q;

endmodule : ball_motion
`default_nettype wire

// File: tb/tb_ball_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_motion
// Description : Directed self-checking bench for ball_motion.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_motion;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       serve;
    logic       enable;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic       dir_x, dir_y, bounce_x, bounce_y, running;

    int n_pass;
    int n_total;

    ball_motion dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .serve      (serve),
        .enable     (enable),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .dir_x      (dir_x),
        .dir_y      (dir_y),
        .bounce_x   (bounce_x),
        .bounce_y   (bounce_y),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".x0"}, 32'(x0), 316);
        check({tag, ".x1"}, 32'(x1), 323);
        check({tag, ".y0"}, 32'(y0), 236);
        check({tag, ".y1"}, 32'(y1), 243);
        check({tag, ".dir_x"}, 32'(dir_x), 1);
        check({tag, ".dir_y"}, 32'(dir_y), 1);
        check({tag, ".bounce_x"}, 32'(bounce_x), 0);
        check({tag, ".bounce_y"}, 32'(bounce_y), 0);
        check({tag, ".running"}, 32'(running), 0);
    endtask

    initial begin
        int px, py;
        n_pass     = 0;
        n_total    = 0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        serve      = 1'b0;
        enable     = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check_reset_state("rst");

        // IDLE ignores frame ticks
        ticks(3);
        check("idle.x0", 32'(x0), 316);
        check("idle.y0", 32'(y0), 236);
        check("idle.running", 32'(running), 0);

        // Serve with a coincident tick: enter RUN, no movement
        serve      = 1'b1;
        frame_tick = 1'b1;
        cycle();
        serve      = 1'b0;
        frame_tick = 1'b0;
        check("serve.running", 32'(running), 1);
        check("serve.x0", 32'(x0), 316);

        ticks(1);
        check("t1.x0", 32'(x0), 318);
        check("t1.y0", 32'(y0), 238);
        check("t1.dir_x", 32'(dir_x), 1);
        check("t1.dir_y", 32'(dir_y), 1);

        ticks(116);
        check("t117.y0", 32'(y0), 470);
        check("t117.bounce_y", 32'(bounce_y), 0);
        ticks(1);
        check("t118.y0", 32'(y0), 472);
        check("t118.y1", 32'(y1), 479);
        check("t118.dir_y", 32'(dir_y), 0);
        check("t118.bounce_y", 32'(bounce_y), 1);
        check("t118.bounce_x", 32'(bounce_x), 0);
        check("t118.x0", 32'(x0), 552);
        cycle();
        check("t118p.bounce_y", 32'(bounce_y), 0);
        check("t118p.y0", 32'(y0), 472);

`ifdef BALL_SPEEDUP_EN
        ticks(1);
        check("t119.x0", 32'(x0), 555);
        check("t119.y0", 32'(y0), 469);
        px = 555;
        py = 469;
`else
        ticks(39);
        check("t157.x0", 32'(x0), 630);
        check("t157.bounce_x", 32'(bounce_x), 0);
        ticks(1);
        check("t158.x0", 32'(x0), 632);
        check("t158.x1", 32'(x1), 639);
        check("t158.dir_x", 32'(dir_x), 0);
        check("t158.bounce_x", 32'(bounce_x), 1);
        check("t158.y0", 32'(y0), 392);
        check("t158.dir_y", 32'(dir_y), 0);
        cycle();
        check("t158p.bounce_x", 32'(bounce_x), 0);
        px = 632;
        py = 392;
`endif

        // Pause: ticks with enable low leave the ball frozen
        enable = 1'b0;
        ticks(10);
        check("pause.x0", 32'(x0), 32'(px));
        check("pause.y0", 32'(y0), 32'(py));
        check("pause.running", 32'(running), 1);
        enable = 1'b1;
        ticks(1);
`ifdef BALL_SPEEDUP_EN
        check("resume.x0", 32'(x0), 32'(px + 3));
        check("resume.y0", 32'(y0), 32'(py - 3));
`else
        check("resume.x0", 32'(x0), 32'(px - 2));
        check("resume.y0", 32'(y0), 32'(py - 2));
`endif

        // Reset mid-motion with a pending tick
        ticks(5);
        reset      = 1'b1;
        frame_tick = 1'b1;
        cycle();
        reset      = 1'b0;
        frame_tick = 1'b0;
        check_reset_state("rst2");

        serve = 1'b1;
        cycle();
        serve = 1'b0;
        ticks(1);
        check("restart.x0", 32'(x0), 318);
        check("restart.y0", 32'(y0), 238);
        check("restart.running", 32'(running), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ball_motion
`default_nettype wire
